// File: rtl/adc_pkg.sv
// ----------------------------------------------------------------------------
// adc_pkg
// Shared constants and helpers for the ADC capture front end.
//   ADC_WIDTH        : default sample width in bits (two's complement samples)
//   max_pos_code(w)  : most-positive two's complement code for a w-bit sample
//   max_neg_code(w)  : most-negative two's complement code for a w-bit sample
// Both helpers return a 32-bit pattern; callers truncate to their width.
// ----------------------------------------------------------------------------
package adc_pkg;

    localparam int ADC_WIDTH = 10;

    // 0 followed by all ones, e.g. 0x1FF for width 10.
    function automatic logic [31:0] max_pos_code(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // 1 followed by all zeros, e.g. 0x200 for width 10.
    function automatic logic [31:0] max_neg_code(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/adc_clk_sync.sv
// ----------------------------------------------------------------------------
// adc_clk_sync
// Brings a slow, free-running clock-like signal into the clk domain as data
// and emits a one-cycle pulse for each low-to-high transition.
//   Parameters : RESET_VAL - value loaded into both sync stages and history
//   clk        : input  - system clock
//   rst        : input  - synchronous, active-high reset
//   async_in   : input  - asynchronous level to synchronise (adc_clk)
//   sync_out   : output - synchronised level (sync stage 2)
//   rise_pulse : output - registered one-cycle pulse on a detected rising edge
// ----------------------------------------------------------------------------
module adc_clk_sync
    import adc_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic sync_1;
    logic sync_2;
    logic history;

    // NOTE: every register here uses non-blocking assignment so the three
    // stages shift as a chain in one edge instead of collapsing into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: resetting the chain to 1 means an input that is already
            // high at reset release looks like "no change", not a rising edge.
            sync_1     <= RESET_VAL;
            sync_2     <= RESET_VAL;
            history    <= RESET_VAL;
            rise_pulse <= 1'b0;
        end else begin
            sync_1     <= async_in;
            sync_2     <= sync_1;
            history    <= sync_2;
            rise_pulse <= sync_2 & ~history;
        end
    end

    assign sync_out = sync_2;

endmodule

// File: rtl/adc_interface.sv
// ----------------------------------------------------------------------------
// adc_interface
// Captures samples from a parallel ADC. adc_clk is sampled as data; on each
// detected rising edge one sample is registered onto data_out together with a
// single-cycle data_valid strobe. A sticky overflow flag records any captured
// sample at the most-positive or most-negative code.
//
// Build option: define ADC_INTERFACE_OFFSET_BINARY_EN when the converter
// produces offset-binary codes; the MSB is then inverted at capture so that
// data_out (and clip detection) always see two's complement.
//
// Ports
//   clk           : input               - system clock
//   rst           : input               - synchronous, active-high reset
//   adc_data      : input  [ADC_WIDTH]  - raw ADC bus (asynchronous)
//   adc_clk       : input               - ADC sample clock, treated as data
//   data_out      : output [ADC_WIDTH]  - captured sample, two's complement
//   data_valid    : output              - one-cycle strobe, data_out updated
//   overflow_flag : output              - sticky clip indicator, cleared by rst
// ----------------------------------------------------------------------------
module adc_interface
    import adc_pkg::*;
#(
    parameter int ADC_WIDTH = adc_pkg::ADC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_clk,
    output logic [ADC_WIDTH-1:0] data_out,
    output logic                 data_valid,
    output logic                 overflow_flag
);

    localparam logic [ADC_WIDTH-1:0] MAX_POS = ADC_WIDTH'(max_pos_code(ADC_WIDTH));
    localparam logic [ADC_WIDTH-1:0] MAX_NEG = ADC_WIDTH'(max_neg_code(ADC_WIDTH));

    logic                 adc_clk_sync_level;
    logic                 adc_rise;
    logic [ADC_WIDTH-1:0] data_s1;
    logic [ADC_WIDTH-1:0] data_s2;
    logic [ADC_WIDTH-1:0] capture_value;
    logic                 capture_clip;

    adc_clk_sync #(
        .RESET_VAL (1'b1)
    ) u_adc_clk_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (adc_clk),
        .sync_out   (adc_clk_sync_level),
        .rise_pulse (adc_rise)
    );

    // Two data stages run alongside the two synchroniser stages. The bus is
    // stable for a whole ADC period, so stage 2 still holds the sample when
    // the registered edge pulse arrives one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            data_s1 <= adc_data;
            data_s2 <= data_s1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        capture_value = data_s2;
`ifdef ADC_INTERFACE_OFFSET_BINARY_EN
        // Offset binary to two's complement: invert the sign bit.
        capture_value[ADC_WIDTH-1] = ~data_s2[ADC_WIDTH-1];
`endif
        capture_clip = (capture_value == MAX_POS) || (capture_value == MAX_NEG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out      <= '0;
            data_valid    <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            data_valid <= adc_rise;
            if (adc_rise) begin
                data_out <= capture_value;
                // Sticky: only ever set here, only rst clears it.
                if (capture_clip) begin
                    overflow_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_interface.sv
// ----------------------------------------------------------------------------
// tb_adc_interface
// Scoreboard bench for adc_interface. The stimulus thread drives adc_clk and
// adc_data from a table of directed vectors and queues the hand-computed
// expected sample, flag and arrival cycle for each adc_clk rising edge. A
// monitor pops and compares whenever data_valid is seen, and reports samples
// that never arrive. Define ADC_INTERFACE_OFFSET_BINARY_EN for both the RTL
// and the bench to exercise the offset-binary build.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adc_interface;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] adc_data = '0;
    logic         adc_clk = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         overflow_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         ovf;
        int           due;
    } exp_t;

    // kind: 0 = plain sample, 1 = reset first, 2 = reset with a sample in flight
    typedef struct {
        int           kind;
        logic [W-1:0] raw;
        logic [W-1:0] exp;
        logic         ovf;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    bit fast_en = 1'b0;

    adc_interface #(
        .ADC_WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .adc_data      (adc_data),
        .adc_clk       (adc_clk),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .overflow_flag (overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: counts cycles and samples outputs 2 ns after each active edge.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #2;
        if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(data_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
                check("overflow_flag", 32'(overflow_flag), 32'(e.ovf));
                check("valid_latency", 32'(cyc), 32'(e.due));
            end
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            e = exp_q.pop_front();
            check("missing_valid", 32'(data_valid), 32'd1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #2;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_overflow", 32'(overflow_flag), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full ADC period: 4 clk low with new data, then 4 clk high.
    // The rising edge is first sampled at the next posedge (N); the valid
    // is expected after posedge N+3, i.e. cycle count at push plus 4.
    task automatic send_sample(input logic [W-1:0] raw, input logic [W-1:0] exp, input logic ovf);
        exp_t e;
        @(negedge clk);
        adc_clk  = 1'b0;
        adc_data = raw;
        repeat (4) @(negedge clk);
        adc_clk = 1'b1;
        e.data = exp;
        e.ovf  = ovf;
        e.due  = cyc + 4;
        exp_q.push_back(e);
        repeat (3) @(negedge clk);
    endtask

    // Raise adc_clk, then reset one cycle later so the capture is dropped.
    task automatic inflight_reset(input logic [W-1:0] raw);
        exp_t e;
        @(negedge clk);
        adc_clk  = 1'b0;
        adc_data = raw;
        repeat (4) @(negedge clk);
        adc_clk = 1'b1;
        e.data = raw;
        e.ovf  = 1'b0;
        e.due  = cyc + 4;
        exp_q.push_back(e);
        do_reset();
        // adc_clk is still high: no capture may appear without a fresh edge.
        repeat (8) begin
            @(posedge clk);
            #2;
            check("dropped_valid", 32'(data_valid), 32'd0);
        end
    endtask

    initial begin
`ifdef ADC_INTERFACE_OFFSET_BINARY_EN
        vecs.push_back('{0, 10'h300, 10'h100, 1'b0});
        vecs.push_back('{0, 10'h300, 10'h100, 1'b0});
        vecs.push_back('{0, 10'h300, 10'h100, 1'b0});
        vecs.push_back('{0, 10'h3FF, 10'h1FF, 1'b1});
        vecs.push_back('{0, 10'h200, 10'h000, 1'b1});
        vecs.push_back('{0, 10'h000, 10'h200, 1'b1});
        vecs.push_back('{2, 10'h2AA, 10'h0AA, 1'b0});
        vecs.push_back('{1, 10'h000, 10'h200, 1'b1});
        vecs.push_back('{1, 10'h201, 10'h001, 1'b0});
        vecs.push_back('{0, 10'h1FE, 10'h3FE, 1'b0});
`else
        vecs.push_back('{0, 10'h100, 10'h100, 1'b0});
        vecs.push_back('{0, 10'h100, 10'h100, 1'b0});
        vecs.push_back('{0, 10'h100, 10'h100, 1'b0});
        vecs.push_back('{0, 10'h1FF, 10'h1FF, 1'b1});
        vecs.push_back('{0, 10'h000, 10'h000, 1'b1});
        vecs.push_back('{0, 10'h200, 10'h200, 1'b1});
        vecs.push_back('{0, 10'h100, 10'h100, 1'b1});
        vecs.push_back('{2, 10'h155, 10'h155, 1'b0});
        vecs.push_back('{1, 10'h200, 10'h200, 1'b1});
        vecs.push_back('{1, 10'h201, 10'h201, 1'b0});
        vecs.push_back('{0, 10'h1FE, 10'h1FE, 1'b0});
`endif

        // Reset held 10 cycles while adc_clk toggles at 52.5 MHz.
        rst      = 1'b1;
        adc_data = 10'h1FF;
        fast_en  = 1'b1;
        fork
            begin
                while (fast_en) begin
                    #9.524 adc_clk = ~adc_clk;
                end
            end
        join_none
        repeat (10) begin
            @(posedge clk);
            #2;
            check("hold_data_out", 32'(data_out), 32'd0);
            check("hold_overflow", 32'(overflow_flag), 32'd0);
            check("hold_valid", 32'(data_valid), 32'd0);
        end
        fast_en = 1'b0;
        #20;
        @(negedge clk);
        adc_clk = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // adc_clk high at release: no valid until a full low-to-high.
        repeat (8) begin
            @(posedge clk);
            #2;
            check("release_valid", 32'(data_valid), 32'd0);
        end

        foreach (vecs[i]) begin
            if (vecs[i].kind == 1) begin
                do_reset();
            end else if (vecs[i].kind == 2) begin
                inflight_reset(vecs[i].raw);
            end
            send_sample(vecs[i].raw, vecs[i].exp, vecs[i].ovf);
        end

        repeat (12) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_interface.md
# adc_interface

Front-end capture block between the external parallel ADC and the DSP chain. It samples the ADC bus and the ADC's free-running sample clock `adc_clk` as ordinary inputs in the `clk` domain. On each detected `adc_clk` rising edge it presents one registered sample with a single-cycle valid strobe, and it latches a sticky overflow flag whenever the converter reports a clipped code.

## Interface
- `ADC_WIDTH`, 10: sample width in bits; samples are two's complement.
- `clk`  input  1: system clock, 100 MHz nominal; the only clock in the block.
- `rst`  input  1: synchronous, active-high reset.
- `adc_data`  input  ADC_WIDTH: raw ADC bus, asynchronous to `clk`, stable for a full `adc_clk` period.
- `adc_clk`  input  1: ADC sample clock, treated as data; frequency below `clk`/2.
- `data_out`  output  ADC_WIDTH: captured sample, two's complement.
- `data_valid`  output  1: one-cycle strobe, `data_out` updated this cycle.
- `overflow_flag`  output  1: sticky; set once a clipped sample is captured.

One clock; reset is synchronous and active-high.

## Operation
- `adc_clk` passes through a 2-FF synchronizer and then a history register. A rising edge is detected when sync stage 2 = 1 and history = 0.
- `adc_data` passes through two register stages aligned with the synchronizer. Stage 2 is the capture source.
- On a detected edge:
  - `data_out` <= capture source.
  - `data_valid` = 1 for exactly one `clk` cycle.
- With no edge, `data_out` holds its value and `data_valid` = 0.
- Clip detection: a captured value equal to the most-positive code (0x1FF for width 10) or the most-negative code (0x200) sets `overflow_flag`. Detection is evaluated only on capture cycles.
- `overflow_flag` remains 1 until `rst`. No other clear path exists.
- Input wider than ADC_WIDTH is not possible at the port. Upper bits driven by the environment are discarded by truncation.
- No arithmetic is applied to the sample except the optional format conversion described under Configuration.

## Timing
- Reset values:
  - `data_out` = 0, `data_valid` = 0, `overflow_flag` = 0.
  - Data pipeline = 0.
  - Synchronizer stages and history = 1, so an `adc_clk` already high at reset release produces no spurious edge.
- Latency: an `adc_clk` rising edge sampled at `clk` edge N produces `data_valid` = 1 and a new `data_out` on the outputs after `clk` edge N+3 (three register stages).
- `overflow_flag` rises on the same cycle as the `data_valid` of the clipped sample.
- `adc_clk` ≥ `clk`/2: edges may be missed. No error is reported. This is outside the supported range.
- `rst` asserted mid-operation: all state returns to reset values on that edge. A valid in flight is dropped. The first post-reset capture needs a fresh low→high of `adc_clk`.
- `rst` and a detected edge in the same cycle: reset wins.

## Configuration
- `ADC_INTERFACE_OFFSET_BINARY_EN`:
  - Defined: `adc_data` is offset-binary. The MSB is inverted at capture, so `data_out` is always two's complement. Clip detection operates on the converted value; raw 0x3FF and 0x000 are the clip codes.
  - Undefined: `adc_data` is already two's complement and passes unchanged.

## Structure
- Package `adc_pkg`:
  - Default `ADC_WIDTH`.
  - Functions or localparams for the max-positive and max-negative codes as a function of width.
- Sub-module `adc_clk_sync`: 2-FF synchronizer plus history register, rising-edge pulse output, parameterized reset value. It is instantiated once.
- The data pipeline, capture register and overflow logic live in the top.

## Test plan
- Reset: hold `rst` 10 cycles with `adc_clk` toggling at 52.5 MHz -> all outputs 0, no `data_valid`. Release -> first `data_valid` only after a full low→high of `adc_clk`.
- Normal capture: `adc_data` = 0x100 held, `adc_clk` toggling -> one `data_valid` per `adc_clk` rising edge, 3 `clk` cycles after the edge, `data_out` = 0x100, `overflow_flag` = 0.
- Sequence 0x1FF, 0x000, 0x200, 0x100, each held one ADC period -> `data_out` follows in order. `overflow_flag` rises on the 0x1FF capture and stays 1 through 0x000 and 0x100.
- Negative clip alone (after reset): `adc_data` = 0x200 -> `overflow_flag` = 1. Non-clipping 0x201 in a fresh run -> flag stays 0.
- Mid-run `rst` pulse of 1 cycle -> `overflow_flag` and `data_out` return to 0 next cycle. Capture resumes on a subsequent edge.
- With `ADC_INTERFACE_OFFSET_BINARY_EN` defined: raw 0x3FF -> `data_out` = 0x1FF with overflow set. Raw 0x200 -> `data_out` = 0x000.
